// File: rtl/calc1_pkg.sv
// calc1_pkg: shared definitions for the calc1 request/response protocol.
//   Command codes   : CMD_NONE, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR
//   Response codes  : RESP_NONE, RESP_OK, RESP_ERR
//   calc1_state_t   : port responder FSM states
package calc1_pkg;

   localparam logic [3:0] CMD_NONE = 4'd0;
   localparam logic [3:0] CMD_ADD  = 4'd1;
   localparam logic [3:0] CMD_SUB  = 4'd2;
   localparam logic [3:0] CMD_SHL  = 4'd5;
   localparam logic [3:0] CMD_SHR  = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OP2  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } calc1_state_t;

endpackage

// File: rtl/calc1_alu.sv
// calc1_alu: combinational calc1 arithmetic unit (unsigned operands).
// Ports:
//   cmd  in  4       command code
//   op1  in  DATA_W  operand1
//   op2  in  DATA_W  operand2 (shift amount taken from op2[4:0])
//   resp out 2       RESP_OK or RESP_ERR
//   data out DATA_W  result, zero whenever resp is RESP_ERR
module calc1_alu
   import calc1_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        cmd,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   output logic [1:0]        resp,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W:0] sum;
   logic [4:0]      shamt;

   always_comb begin
      sum   = {1'b0, op1} + {1'b0, op2};
      shamt = op2[4:0];
      resp  = RESP_ERR;
      data  = '0;
      case (cmd)
         CMD_ADD: begin
            // Carry out of the top bit is reported as overflow.
            if (!sum[DATA_W]) begin
               resp = RESP_OK;
               data = sum[DATA_W-1:0];
            end
         end
         CMD_SUB: begin
            if (op2 <= op1) begin
               resp = RESP_OK;
               data = op1 - op2;
            end
         end
         CMD_SHL: begin
            resp = RESP_OK;
            data = op1 << shamt;
         end
         CMD_SHR: begin
            resp = RESP_OK;
            data = op1 >> shamt;
         end
         default: begin
            resp = RESP_ERR;
            data = '0;
         end
      endcase
   end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1_port_responder: single-port calc1 request responder.
// Captures command + operand1, then operand2 on the next cycle, and presents
// a one-cycle response LATENCY cycles after operand2 capture.
// Ports:
//   c_clk        in   1           clock, rising edge
//   reset_n      in   1           asynchronous reset, active-low
//   req_cmd_in   in   4           command (0 none, 1 add, 2 sub, 5 shl, 6 shr)
//   req_data_in  in   DATA_W      operand1 in command cycle, operand2 next cycle
//   out_resp     out  2           0 none, 1 ok, 2 error
//   out_data     out  DATA_W      result when out_resp==1, else 0
//   busy         out  1           high from operand2 capture through response
//   drop_cnt     out  DROP_CNT_W  saturating count of commands ignored while busy
module calc1_port_responder
   import calc1_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 2,
   parameter int DROP_CNT_W = 8
) (
   input  logic                  c_clk,
   input  logic                  reset_n,
   input  logic [3:0]            req_cmd_in,
   input  logic [DATA_W-1:0]     req_data_in,
   output logic [1:0]            out_resp,
   output logic [DATA_W-1:0]     out_data,
   output logic                  busy,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

   calc1_state_t      state, state_nxt;
   logic [3:0]        cmd_p0;
   logic [DATA_W-1:0] op1_p0;
   logic [DATA_W-1:0] op2_p1;
   logic [3:0]        wait_cnt;
   logic [1:0]        alu_resp;
   logic [DATA_W-1:0] alu_data;
   logic              cmd_valid;
   logic              accept;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

   assign cmd_valid = (req_cmd_in != CMD_NONE);
   // The response cycle also accepts a new command, so back-to-back
   // operations run at one per LATENCY+2 cycles.
   assign accept = cmd_valid && ((state == ST_IDLE) || (state == ST_RESP));

   calc1_alu #(.DATA_W(DATA_W)) u_alu (
      .cmd  (cmd_p0),
      .op1  (op1_p0),
      .op2  (op2_p1),
      .resp (alu_resp),
      .data (alu_data)
   );

   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      out_resp  = RESP_NONE;
      out_data  = '0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_OP2;
         end
         ST_OP2: begin
            state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            if (wait_cnt == 4'd0) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            busy      = 1'b1;
            out_resp  = alu_resp;
            out_data  = alu_data;
            state_nxt = accept ? ST_OP2 : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Stage p0: command/operand1 capture; stage p1: operand2 capture.
   always_ff @(posedge c_clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_p0   <= '0;
         op1_p0   <= '0;
         op2_p1   <= '0;
         wait_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (accept) begin
            cmd_p0 <= req_cmd_in;
            op1_p0 <= req_data_in;
         end
         if (state == ST_OP2) begin
            op2_p1   <= req_data_in;
            wait_cnt <= WAIT_INIT;
         end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if ((state == ST_WAIT) && cmd_valid) drop_cnt <= sat_inc(drop_cnt);
      end
   end

endmodule

// File: tb/tb_calc1_port_responder.sv
module tb_calc1_port_responder;

   logic        c_clk;
   logic        reset_n;
   logic [3:0]  req_cmd_in;
   logic [31:0] req_data_in;
   logic [1:0]  out_resp;
   logic [31:0] out_data;
   logic        busy;
   logic [7:0]  drop_cnt;

   int vectors = 0;
   int errors  = 0;

   calc1_port_responder #(.DATA_W(32), .LATENCY(2), .DROP_CNT_W(8)) dut (
      .c_clk       (c_clk),
      .reset_n     (reset_n),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .busy        (busy),
      .drop_cnt    (drop_cnt)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   // Issues one operation; returns just after the response becomes visible.
   task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
      req_cmd_in  = c;
      req_data_in = a;
      step();
      chk({tag, "_op2_busy"}, 64'(busy), 64'd0);
      req_cmd_in  = 4'd0;
      req_data_in = b;
      step();
      chk({tag, "_wait_busy"}, 64'(busy), 64'd1);
      chk({tag, "_wait_resp"}, 64'(out_resp), 64'd0);
      req_data_in = 32'hDEAD_BEEF;
      step();
      step();
      chk({tag, "_resp"}, 64'(out_resp), 64'(er));
      chk({tag, "_data"}, 64'(out_data), 64'(ed));
      chk({tag, "_resp_busy"}, 64'(busy), 64'd1);
   endtask

   task automatic idle_after(input string tag);
      step();
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
      chk({tag, "_idle_resp"}, 64'(out_resp), 64'd0);
      chk({tag, "_idle_data"}, 64'(out_data), 64'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      req_cmd_in  = 4'd0;
      req_data_in = 32'd0;
      step();
      step();
      chk("rst_resp", 64'(out_resp), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      reset_n = 1'b1;
      step();

      do_op("add", 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
      idle_after("add");
      do_op("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
      idle_after("add_ovf");
      do_op("sub_unf", 4'd2, 32'h1, 32'hF, 2'd2, 32'h0);
      idle_after("sub_unf");
      do_op("sub_ok", 4'd2, 32'hF, 32'h1, 2'd1, 32'hE);
      idle_after("sub_ok");
      do_op("shl", 4'd5, 32'h1, 32'h21, 2'd1, 32'h2);
      idle_after("shl");
      do_op("shr", 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h1);
      idle_after("shr");
      do_op("inv3", 4'd3, 32'h1234, 32'h1, 2'd2, 32'h0);
      idle_after("inv3");
      do_op("inv4", 4'd4, 32'h1, 32'h1, 2'd2, 32'h0);
      idle_after("inv4");

      for (int i = 0; i < 20; i++) begin
         req_cmd_in  = 4'd0;
         req_data_in = $urandom;
         step();
         chk("idle_resp", 64'(out_resp), 64'd0);
         chk("idle_busy", 64'(busy), 64'd0);
      end

      // Drop during WAIT, then a back-to-back command in the response cycle.
      req_cmd_in  = 4'd1;
      req_data_in = 32'd2;
      step();
      req_cmd_in  = 4'd0;
      req_data_in = 32'd3;
      step();
      req_cmd_in  = 4'd1;
      req_data_in = 32'h5555_5555;
      step();
      chk("drop_cnt", 64'(drop_cnt), 64'd1);
      req_cmd_in  = 4'd0;
      step();
      chk("b2b_a_resp", 64'(out_resp), 64'd1);
      chk("b2b_a_data", 64'(out_data), 64'd5);
      do_op("b2b_b", 4'd1, 32'd10, 32'd20, 2'd1, 32'd30);
      chk("b2b_drop_hold", 64'(drop_cnt), 64'd1);
      idle_after("b2b_b");

      // Reset in the middle of an operation.
      req_cmd_in  = 4'd1;
      req_data_in = 32'd5;
      step();
      req_cmd_in  = 4'd0;
      req_data_in = 32'd6;
      step();
      chk("mid_busy_pre", 64'(busy), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_resp", 64'(out_resp), 64'd0);
      chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
      step();
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_resp", 64'(out_resp), 64'd0);
         chk("post_rst_busy", 64'(busy), 64'd0);
      end
      do_op("post_rst_add", 4'd1, 32'd0, 32'd0, 2'd1, 32'd0);
      idle_after("post_rst_add");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
